// File: rtl/pipeline_pkg.sv
// ============================================================================
// pipeline_pkg : shared instruction-type / funct3 codes and mem-stage states
// Revision     : 1.0
// ============================================================================
`default_nettype none

package pipeline_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] IT_RTYPE  = 3'b011;
  localparam logic [2:0] IT_ITYPE  = 3'b001;
  localparam logic [2:0] IT_LOAD   = 3'b000;
  localparam logic [2:0] IT_STORE  = 3'b010;
  localparam logic [2:0] IT_BRANCH = 3'b110;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [0:0] {
    S_IDLE     = 1'b0,
    S_MEM_WAIT = 1'b1
  } state_e;

  function automatic logic ls_legal(input logic is_store, input logic [2:0] f3);
    if (is_store) begin
      return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    end
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) || (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_lane_align.sv
// ============================================================================
// mem_lane_align : byte-lane steering for stores, extraction/extension for loads
// Revision       : 1.0
// ============================================================================
`default_nettype none

module mem_lane_align
  import pipeline_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic        misalign
);

  logic [7:0]  lane_byte;
  logic [15:0] lane_half;

  always_comb begin
    lane_byte = rdata[7:0];
    case (addr_lo)
      2'd1:    lane_byte = rdata[15:8];
      2'd2:    lane_byte = rdata[23:16];
      2'd3:    lane_byte = rdata[31:24];
      default: lane_byte = rdata[7:0];
    endcase
    lane_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    // funct3[1:0] encodes the access size for both loads and stores
    be       = 4'b0000;
    wdata    = 32'd0;
    misalign = 1'b0;
    case (funct3[1:0])
      2'b00: begin
        be    = 4'b0001 << addr_lo;
        wdata = {4{store_data[7:0]}};
      end
      2'b01: begin
        be       = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata    = {2{store_data[15:0]}};
        misalign = addr_lo[0];
      end
      2'b10: begin
        be       = 4'b1111;
        wdata    = store_data;
        misalign = |addr_lo;
      end
      default: ;
    endcase

    case (funct3)
      F3_B:    load_data = {{24{lane_byte[7]}}, lane_byte};
      F3_H:    load_data = {{16{lane_half[15]}}, lane_half};
      F3_W:    load_data = rdata;
      F3_BU:   load_data = {24'd0, lane_byte};
      F3_HU:   load_data = {16'd0, lane_half};
      default: load_data = 32'd0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mem_stage.sv
// ============================================================================
// mem_stage : memory-access stage -- LOAD/STORE req/ack, ALU result passthrough
// Revision  : 1.0
// ============================================================================
`default_nettype none

module mem_stage #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_itype,
  input  logic [XLEN-1:0] in_alu_out,
  input  logic [2:0]      in_funct3,
  input  logic [XLEN-1:0] in_store_data,
  input  logic [4:0]      in_rd,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [3:0]      mem_be,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_ack,
  output logic            wb_valid,
  output logic            wb_we,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            err
);

  import pipeline_pkg::*;

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [XLEN-1:0]   mem_addr_q, mem_addr_d;
  logic [3:0]        mem_be_q, mem_be_d;
  logic [XLEN-1:0]   mem_wdata_q, mem_wdata_d;
  logic [4:0]        rd_q, rd_d;
  logic [2:0]        f3_q, f3_d;
  logic [1:0]        addr_lo_q, addr_lo_d;
  logic              wb_valid_q, wb_valid_d;
  logic              wb_we_q, wb_we_d;
  logic [4:0]        wb_rd_q, wb_rd_d;
  logic [XLEN-1:0]   wb_data_q, wb_data_d;
  logic              err_q, err_d;

  logic              is_store;
  logic              timeout_hit;
  logic [1:0]        lane_addr;
  logic [2:0]        lane_f3;
  logic [3:0]        lane_be;
  logic [31:0]       lane_wdata;
  logic [31:0]       lane_ldata;
  logic              lane_mis;

  // One aligner serves both directions: request fields in IDLE, load data in MEM_WAIT
  assign lane_addr = (state_q == S_IDLE) ? in_alu_out[1:0] : addr_lo_q;
  assign lane_f3   = (state_q == S_IDLE) ? in_funct3 : f3_q;

  mem_lane_align u_align (
    .addr_lo    (lane_addr),
    .funct3     (lane_f3),
    .store_data (in_store_data),
    .rdata      (mem_rdata),
    .be         (lane_be),
    .wdata      (lane_wdata),
    .load_data  (lane_ldata),
    .misalign   (lane_mis)
  );

  assign cnt_inc     = cnt_q + CNT_W'(1);
  assign timeout_hit = (TIMEOUT != 0) && (cnt_inc == TO_VAL);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    rd_d        = rd_q;
    f3_d        = f3_q;
    addr_lo_d   = addr_lo_q;
    wb_valid_d  = 1'b0;
    wb_we_d     = 1'b0;
    wb_rd_d     = 5'd0;
    wb_data_d   = '0;
    err_d       = 1'b0;
    is_store    = (in_itype == IT_STORE);

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          case (in_itype)
            IT_RTYPE, IT_ITYPE: begin
              wb_valid_d = 1'b1;
              wb_we_d    = (in_rd != 5'd0);
              wb_rd_d    = in_rd;
              wb_data_d  = in_alu_out;
            end
            IT_LOAD, IT_STORE: begin
              if (!ls_legal(is_store, in_funct3) || lane_mis) begin
                err_d = 1'b1;
              end else begin
                state_d     = S_MEM_WAIT;
                cnt_d       = '0;
                mem_req_d   = 1'b1;
                mem_we_d    = is_store;
                mem_addr_d  = {in_alu_out[XLEN-1:2], 2'b00};
                mem_be_d    = lane_be;
                mem_wdata_d = is_store ? lane_wdata : '0;
                rd_d        = in_rd;
                f3_d        = in_funct3;
                addr_lo_d   = in_alu_out[1:0];
              end
            end
            default: ;
          endcase
        end
      end
      S_MEM_WAIT: begin
        if (mem_ack || timeout_hit) begin
          state_d     = S_IDLE;
          cnt_d       = '0;
          mem_req_d   = 1'b0;
          mem_we_d    = 1'b0;
          mem_addr_d  = '0;
          mem_be_d    = 4'b0000;
          mem_wdata_d = '0;
          // ack takes priority over a coincident timeout
          if (mem_ack) begin
            if (!mem_we_q) begin
              wb_valid_d = 1'b1;
              wb_we_d    = (rd_q != 5'd0);
              wb_rd_d    = rd_q;
              wb_data_d  = lane_ldata;
            end
          end else begin
            err_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= 4'b0000;
      mem_wdata_q <= '0;
      rd_q        <= 5'd0;
      f3_q        <= 3'd0;
      addr_lo_q   <= 2'd0;
      wb_valid_q  <= 1'b0;
      wb_we_q     <= 1'b0;
      wb_rd_q     <= 5'd0;
      wb_data_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      rd_q        <= rd_d;
      f3_q        <= f3_d;
      addr_lo_q   <= addr_lo_d;
      wb_valid_q  <= wb_valid_d;
      wb_we_q     <= wb_we_d;
      wb_rd_q     <= wb_rd_d;
      wb_data_q   <= wb_data_d;
      err_q       <= err_d;
    end
  end

  assign in_ready  = rst_n && (state_q == S_IDLE);
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_be    = mem_be_q;
  assign mem_wdata = mem_wdata_q;
  assign wb_valid  = wb_valid_q;
  assign wb_we     = wb_we_q;
  assign wb_rd     = wb_rd_q;
  assign wb_data   = wb_data_q;
  assign err       = err_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_stage.sv
// ============================================================================
// tb_mem_stage : scoreboard bench for mem_stage with a behavioural memory model
// Revision     : 1.0
// ============================================================================
`default_nettype none

module tb_mem_stage;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_itype;
  logic [31:0] in_alu_out;
  logic [2:0]  in_funct3;
  logic [31:0] in_store_data;
  logic [4:0]  in_rd;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        wb_valid;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        err;

  always #5 clk = ~clk;

  mem_stage #(.XLEN(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_itype(in_itype), .in_alu_out(in_alu_out), .in_funct3(in_funct3),
    .in_store_data(in_store_data), .in_rd(in_rd), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .wb_valid(wb_valid), .wb_we(wb_we),
    .wb_rd(wb_rd), .wb_data(wb_data), .err(err)
  );

  typedef struct {
    bit          is_err;
    bit          we;
    logic [4:0]  rd;
    logic [31:0] data;
  } out_t;

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    int          w;      // idle cycles of mem_req before the ack
    logic [31:0] rdata;
  } mem_t;

  out_t outq[$];
  mem_t memq[$];
  int   vectors = 0;
  int   miscompares = 0;
  bit   resp_en = 1'b0;
  bit   mon_en = 1'b0;
  logic [2:0] legal_ld [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  // Reference model: derives the memory transaction and the writeback/err outcome of one op
  function automatic void model(input logic [2:0] it, input logic [31:0] a, input logic [2:0] f3,
                                input logic [31:0] sd, input logic [4:0] rd, input int w,
                                input logic [31:0] rdat);
    int size, off;
    bit st, legal;
    logic [31:0] mask, v;
    out_t o;
    mem_t m;
    o = '{is_err: 0, we: 0, rd: 5'd0, data: 32'd0};
    if (it == 3'b011 || it == 3'b001) begin
      o.we = (rd != 0); o.rd = rd; o.data = a;
      outq.push_back(o);
      return;
    end
    if (!(it == 3'b000 || it == 3'b010)) return;
    st    = (it == 3'b010);
    legal = st ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    off   = int'(a % 4);
    if (!legal || (off % size) != 0) begin
      o.is_err = 1;
      outq.push_back(o);
      return;
    end
    mask    = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 32'd1);
    m.we    = st;
    m.addr  = a - off;
    m.be    = 4'(((1 << size) - 1) << off);
    m.wdata = st ? (sd & mask) * ((size == 1) ? 32'h0101_0101 : (size == 2) ? 32'h0001_0001 : 32'h1) : 32'd0;
    m.w     = w;
    m.rdata = rdat;
    memq.push_back(m);
    if (w >= TO) begin
      o.is_err = 1;
      outq.push_back(o);
      return;
    end
    if (st) return;
    v = (rdat >> (8 * off)) & mask;
    if (!f3[2] && size < 4 && v[8 * size - 1]) v = v | ~mask;
    o.we = (rd != 0); o.rd = rd; o.data = v;
    outq.push_back(o);
  endfunction

  // Memory responder: checks request fields/stability and answers after the chosen delay
  mem_t cur;
  bit   active = 1'b0;
  int   hi = 0;
  always @(negedge clk) begin
    if (!resp_en) begin
      active = 1'b0;
    end else begin
      mem_ack   = 1'b0;
      mem_rdata = $urandom;
      if (mem_req) begin
        if (!active) begin
          if (memq.size() == 0) begin
            vectors++; miscompares++;
            $display("FAIL unexpected_req: got addr %h expected no request", mem_addr);
          end else begin
            cur = memq.pop_front(); active = 1'b1; hi = 0;
          end
        end
        if (active) begin
          chk("mem_we", mem_we, cur.we);
          chk("mem_addr", mem_addr, cur.addr);
          chk("mem_be", mem_be, cur.be);
          if (cur.we) chk("mem_wdata", mem_wdata, cur.wdata);
          chk("busy_in_ready", in_ready, 0);
          hi++;
          if (hi == cur.w + 1) begin
            mem_ack = 1'b1; mem_rdata = cur.rdata;
          end
        end
      end else begin
        chk("idle_mem_be_we_wdata", {mem_we, mem_be, mem_wdata[26:0]} | {5'd0, 27'(|mem_wdata)}, 0);
        if (active) begin
          chk("req_cycles", hi, (cur.w >= TO) ? TO : cur.w + 1);
          active = 1'b0;
        end
      end
    end
  end

  out_t mon_e;
  always @(negedge clk) begin
    if (mon_en && rst_n && (wb_valid || err)) begin
      if (outq.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL unexpected_pulse: got wb_valid=%b err=%b expected none", wb_valid, err);
      end else begin
        mon_e = outq.pop_front();
        if (mon_e.is_err) begin
          chk("err", err, 1);
          chk("err_wb_valid", wb_valid, 0);
        end else begin
          chk("wb_valid", wb_valid, 1);
          chk("wb_err", err, 0);
          chk("wb_we", wb_we, mon_e.we);
          chk("wb_rd", wb_rd, mon_e.rd);
          chk("wb_data", wb_data, mon_e.data);
        end
      end
    end
  end

  task automatic issue(input logic [2:0] it, input logic [31:0] a, input logic [2:0] f3,
                       input logic [31:0] sd, input logic [4:0] rd, input int w,
                       input logic [31:0] rdat);
    int g = 0;
    while (!in_ready) begin
      in_valid   = 1'($urandom_range(0, 1));
      in_itype   = 3'b011;
      in_alu_out = $urandom;
      in_rd      = 5'($urandom);
      @(negedge clk);
      g++;
      if (g > 64) begin
        vectors++; miscompares++;
        $display("FAIL issue_wait: got in_ready=0 expected 1 within 64 cycles");
        in_valid = 1'b0;
        return;
      end
    end
    in_valid = 1'b1; in_itype = it; in_alu_out = a; in_funct3 = f3;
    in_store_data = sd; in_rd = rd;
    model(it, a, f3, sd, rd, w, rdat);
    @(negedge clk);
    in_valid = 1'b0; in_alu_out = $urandom; in_store_data = $urandom;
  endtask

  task automatic drain();
    int g = 0;
    while ((outq.size() != 0 || memq.size() != 0 || !in_ready) && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (g >= 100) begin
      vectors++; miscompares++;
      $display("FAIL drain: got %0d outputs pending expected 0", outq.size());
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  it, f3;
    int          r;
    rst_n = 1'b0; in_valid = 1'b0; in_itype = 3'b0; in_alu_out = 32'd0;
    in_funct3 = 3'd0; in_store_data = 32'd0; in_rd = 5'd0;
    mem_ack = 1'b0; mem_rdata = 32'd0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_err", err, 0);
    chk("rst_mem_be", mem_be, 0);
    rst_n = 1'b1; resp_en = 1'b1; mon_en = 1'b1;
    @(negedge clk);
    chk("idle_in_ready", in_ready, 1);

    issue(3'b001, 32'h1234, 3'd0, 32'd0, 5'd5, 0, 32'd0);
    issue(3'b011, 32'h5555, 3'd0, 32'd0, 5'd0, 0, 32'd0);
    issue(3'b000, 32'h103, 3'd0, 32'd0, 5'd7, 2, 32'h80FF_7F01);
    issue(3'b000, 32'h102, 3'd5, 32'd0, 5'd8, 0, 32'hBEEF_0000);
    issue(3'b000, 32'h101, 3'd2, 32'd0, 5'd9, 0, 32'd0);
    issue(3'b010, 32'h21, 3'd0, 32'hAB, 5'd0, 1, 32'd0);
    issue(3'b000, 32'h40, 3'd2, 32'd0, 5'd3, 10, 32'd0);
    issue(3'b110, 32'h80, 3'd0, 32'd0, 5'd4, 0, 32'd0);
    issue(3'b010, 32'h33, 3'd7, 32'h1, 5'd1, 0, 32'd0);
    drain();

    // Reset in the middle of an outstanding load; the late ack must be ignored
    resp_en = 1'b0;
    in_valid = 1'b1; in_itype = 3'b000; in_alu_out = 32'h200; in_funct3 = 3'd2; in_rd = 5'd4;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk("req_before_rst", mem_req, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_mem_req", mem_req, 0);
    chk("rst_async_in_ready", in_ready, 0);
    @(negedge clk);
    rst_n = 1'b1; mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("late_ack_wb_valid", wb_valid, 0);
    chk("post_rst_in_ready", in_ready, 1);
    repeat (3) @(negedge clk);
    chk("post_rst_mem_req", mem_req, 0);
    resp_en = 1'b1;

    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 9);
      it = (r < 2) ? 3'b011 : (r == 2) ? 3'b001 : (r < 6) ? 3'b000 :
           (r < 8) ? 3'b010 : (r == 8) ? 3'b110 : 3'b111;
      if ($urandom_range(0, 3) == 0) f3 = 3'($urandom_range(0, 7));
      else if (it == 3'b010)         f3 = 3'($urandom_range(0, 2));
      else                           f3 = legal_ld[$urandom_range(0, 4)];
      issue(it, $urandom, f3, $urandom, 5'($urandom_range(0, 31)),
            $urandom_range(0, 6), $urandom);
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end
    drain();
    chk("outq_empty", outq.size(), 0);
    chk("memq_empty", memq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_stage.md
Name: mem_stage

Overview:
Memory-access stage directly downstream of the execute ALU. It consumes the ALU result, the forwarded funct3 and the instruction type.
- LOAD/STORE: runs a req/ack transaction on the data-memory port, with byte-lane steering and load sign/zero extension.
- RTYPE/ITYPE: passes the ALU result straight through to writeback.
- Stalls the execute stage while a memory transaction is outstanding.

Parameters:
XLEN, 32, datapath width; only 32 is supported.
TIMEOUT, 255, cycles to wait for mem_ack before aborting with an error; 0 means wait forever.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  execute result valid
in_ready  out  1  stage can accept a new op this cycle
in_itype  in  3  instruction type: RTYPE 011, ITYPE 001, LOAD 000, STORE 010, BRANCH 110
in_alu_out  in  32  ALU result; the byte address for LOAD/STORE
in_funct3  in  3  funct3 forwarded by the ALU
in_store_data  in  32  rs2 value for stores
in_rd  in  5  destination register
mem_req  out  1  memory request, held until ack
mem_we  out  1  1 = write
mem_addr  out  32  word address (byte address with [1:0] forced to 00)
mem_be  out  4  byte enables
mem_wdata  out  32  lane-steered store data
mem_rdata  in  32  read data, valid only with mem_ack
mem_ack  in  1  one-cycle completion
wb_valid  out  1  one-cycle writeback pulse
wb_we  out  1  register-file write enable
wb_rd  out  5  destination register
wb_data  out  32  writeback value
err  out  1  one-cycle pulse: misalignment, illegal funct3 or timeout

Behaviour:
- Reset (asynchronous, any state, including mid-transaction): state goes to IDLE and every output goes to 0, including mem_req, which drops immediately. The timeout counter clears. A pending ack arriving after reset is ignored.
- States: IDLE, MEM_WAIT.
- in_ready = (state == IDLE). An op is accepted on in_valid && in_ready.
- RTYPE/ITYPE accepted: stay in IDLE. Next cycle: wb_valid=1, wb_data=in_alu_out, wb_rd=in_rd, wb_we=(in_rd!=0). Throughput is one op per cycle.
- BRANCH accepted: no writeback, no error; the op is consumed silently. Any other itype code is also consumed silently.
- LOAD/STORE accepted: check legality first.
  - Legal LOAD funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Legal STORE funct3: 000 SB, 001 SH, 010 SW.
  - Misaligned: halfword with addr[0]=1, or word with addr[1:0]!=00.
  - Illegal funct3 or misaligned: no request is issued; next cycle err=1 and wb_valid=0; stay in IDLE.
  - Otherwise: register the address, byte enables, data, rd and funct3; go to MEM_WAIT. mem_req=1 from the next cycle.
- MEM_WAIT:
  - mem_req, mem_we, mem_addr, mem_be and mem_wdata stay stable until the ack.
  - mem_ack=1: drop mem_req in the next cycle and return to IDLE.
    - Load: the same next cycle gives wb_valid=1 with the extracted data, and wb_we=(rd!=0).
    - Store: no writeback pulse.
  - Load latency = 2 + ack-wait cycles. New ops are accepted again in the cycle after the ack.
- Timeout:
  - The counter increments each cycle in MEM_WAIT without an ack.
  - When TIMEOUT!=0 and the count reaches TIMEOUT: drop mem_req, pulse err, no writeback, return to IDLE.
  - If an ack arrives in the same cycle the count reaches TIMEOUT, the ack wins.
- Store lanes: byte = addr[1:0], half = addr[1].
  - SB: be=0001<<byte, wdata = data[7:0] replicated to all 4 lanes.
  - SH: be=0011<<(2*half), wdata = data[15:0] replicated to both halves.
  - SW: be=1111, wdata = data.
- Load extraction: select the byte/half from mem_rdata using the lane.
  - LB/LH: sign-extend to 32 bits.
  - LBU/LHU: zero-extend.
- In any other case wb_valid, err and the mem_* signals are 0 between events; mem_be and mem_wdata are 0 when mem_req=0.

Decomposition:
- Package pipeline_pkg: itype codes, load/store funct3 codes, FSM state enum, XLEN.
- One combinational sub-module, mem_lane_align: inputs addr[1:0], funct3, store data and rdata; outputs be, steered wdata, extended load data and a misalign flag.
- The FSM, timeout counter and output registers live in mem_stage.

Test Plan:
- ITYPE, alu_out=0x1234, rd=5, accepted back-to-back with RTYPE rd=0 -> consecutive wb pulses: (we=1, rd=5, data=0x1234), then (we=0).
- LB from addr 0x103, rdata=0x80FF_7F01, ack after 3 cycles -> mem_addr=0x100, be=1000 held stable, in_ready=0 throughout; wb_data=0xFFFFFF80.
- LHU from addr 0x102, rdata=0xBEEF_0000 -> wb_data=0x0000BEEF. LW from addr 0x101 -> err pulse, mem_req never asserted.
- SB data=0xAB at addr 0x21 -> be=0010, wdata=0xABABABAB, mem_we=1; no wb pulse; in_ready returns to 1 the cycle after ack.
- TIMEOUT=4, LOAD with ack never asserted -> mem_req high for 4 cycles then drops, err pulse, no wb; the next op is accepted.
- rst_n asserted low during MEM_WAIT -> mem_req=0 immediately; a late ack after release produces no wb pulse.
